// File: rtl/smp_pkg.sv
// smp_pkg: shared opcode, state and control-word definitions for the control unit
// Opcodes occupy ir[3:0]; an instruction is decoded only when ir[7:4] is zero.
// The states are plain logic [3:0] constants so that older code can still use them.
package smp_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;
  localparam logic [3:0] S_FETCH1 = 4'd0;
  localparam logic [3:0] S_FETCH2 = 4'd1;
  localparam logic [3:0] S_FETCH3 = 4'd2;
  localparam logic [3:0] S_ADDR1  = 4'd3;
  localparam logic [3:0] S_ADDR2  = 4'd4;
  localparam logic [3:0] S_ADDR3  = 4'd5;
  localparam logic [3:0] S_JUMPX  = 4'd6;
  localparam logic [3:0] S_SKIP1  = 4'd7;
  localparam logic [3:0] S_SKIP2  = 4'd8;
  localparam logic [3:0] S_LDRD   = 4'd9;
  localparam logic [3:0] S_LDWB   = 4'd10;
  localparam logic [3:0] S_STDR   = 4'd11;
  localparam logic [3:0] S_STWR   = 4'd12;
  localparam logic [3:0] S_EXEC   = 4'd13;
  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       ar_ld_pc;
    logic       ar_ld_dt;
    logic       ar_inc;
    logic       pc_inc;
    logic       pc_ld_dt;
    logic       dr_ld_mem;
    logic       dr_ld_ac;
    logic       tr_ld_dr;
    logic       ir_ld_dr;
    logic       ac_ld;
    logic       r_ld;
    logic       z_ld;
    logic [3:0] alu_op;
    logic       illegal;
  } ctl_t;
endpackage

// File: rtl/control_unit_dec.sv
// control_unit_dec: one-hot instruction decoder
// opcode : 8-bit instruction byte
// hot    : bit n is set for opcode n; all zero when opcode[7:4] != 0, meaning undecoded
module control_unit_dec (
  input  logic [7:0]  opcode,
  output logic [15:0] hot
);
  assign hot = (opcode[7:4] == 4'd0) ? (16'd1 << opcode[3:0]) : 16'd0;
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for the simple microprocessor
// Inputs  : clk, rst_n (async, active low), run, ir (opcode bus seen in FETCH3), z, mem_ready
// Outputs : memory requests, AR/PC/DR/TR/IR/AC/R/Z load strobes, alu_op, and the illegal pulse
module control_unit
  import smp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] ir,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ar_ld_pc,
  output logic       ar_ld_dt,
  output logic       ar_inc,
  output logic       pc_inc,
  output logic       pc_ld_dt,
  output logic       dr_ld_mem,
  output logic       dr_ld_ac,
  output logic       tr_ld_dr,
  output logic       ir_ld_dr,
  output logic       ac_ld,
  output logic       r_ld,
  output logic       z_ld,
  output logic [3:0] alu_op,
  output logic       illegal
);
  logic [3:0]  state, nxt, op;
  logic [15:0] hot;
  logic        en, take, skip;
  ctl_t        c, o;
  control_unit_dec u_dec (.opcode(ir), .hot(hot));
  // The branch decision is taken once, in FETCH3, and is then carried by the state itself.
  // A later change on z therefore cannot alter it.
  assign take = hot[OP_LDAC] | hot[OP_STAC] | hot[OP_JUMP] | (hot[OP_JMPZ] & z) | (hot[OP_JPNZ] & ~z);
  assign skip = (hot[OP_JMPZ] & ~z) | (hot[OP_JPNZ] & z);
  // en stays low from reset until the first rising edge after reset is released.
  // While it is low, all strobes are held off and the state machine waits in FETCH1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH1;
      op    <= 4'd0;
      en    <= 1'b0;
    end else begin
      en    <= 1'b1;
      state <= en ? nxt : S_FETCH1;
      if (en && state == S_FETCH3) op <= ir[3:0];
    end
  always_comb begin
    c   = '0;
    nxt = state;
    case (state)
      S_FETCH1: begin
        c.ar_ld_pc = 1'b1;
        nxt = run ? S_FETCH2 : S_FETCH1;
      end
      S_FETCH2: begin
        c.mem_rd    = 1'b1;
        c.dr_ld_mem = mem_ready;
        c.pc_inc    = mem_ready;
        nxt = mem_ready ? S_FETCH3 : S_FETCH2;
      end
      S_FETCH3: begin
        c.ir_ld_dr = 1'b1;
        c.ar_ld_pc = 1'b1;
        c.illegal  = (hot == 16'd0);
        nxt = (hot == 16'd0 || hot[OP_NOP]) ? S_FETCH1 : take ? S_ADDR1 : skip ? S_SKIP1 : S_EXEC;
      end
      S_ADDR1: begin
        c.mem_rd    = 1'b1;
        c.dr_ld_mem = mem_ready;
        c.pc_inc    = mem_ready;
        c.ar_inc    = mem_ready;
        nxt = mem_ready ? S_ADDR2 : S_ADDR1;
      end
      S_ADDR2: begin
        c.mem_rd    = 1'b1;
        c.tr_ld_dr  = mem_ready;
        c.dr_ld_mem = mem_ready;
        c.pc_inc    = mem_ready;
        nxt = !mem_ready ? S_ADDR2 : (op == OP_LDAC || op == OP_STAC) ? S_ADDR3 : S_JUMPX;
      end
      S_ADDR3: begin
        c.ar_ld_dt = 1'b1;
        nxt = (op == OP_LDAC) ? S_LDRD : S_STDR;
      end
      S_JUMPX: begin
        c.pc_ld_dt = 1'b1;
        nxt = S_FETCH1;
      end
      S_SKIP1: begin
        c.pc_inc = 1'b1;
        nxt = S_SKIP2;
      end
      S_SKIP2: begin
        c.pc_inc = 1'b1;
        nxt = S_FETCH1;
      end
      S_LDRD: begin
        c.mem_rd    = 1'b1;
        c.dr_ld_mem = mem_ready;
        nxt = mem_ready ? S_LDWB : S_LDRD;
      end
      S_LDWB: begin
        c.ac_ld  = 1'b1;
        c.alu_op = 4'd1;
        nxt = S_FETCH1;
      end
      S_STDR: begin
        c.dr_ld_ac = 1'b1;
        nxt = S_STWR;
      end
      S_STWR: begin
        c.mem_wr = 1'b1;
        nxt = mem_ready ? S_FETCH1 : S_STWR;
      end
      S_EXEC: begin
        c.r_ld   = (op == OP_MVAC);
        c.ac_ld  = (op == OP_MOVR) || (op >= OP_ADD);
        c.z_ld   = (op >= OP_ADD);
        c.alu_op = op;
        nxt = S_FETCH1;
      end
      default: nxt = S_FETCH1;
    endcase
  end
  // Every strobe is forced low while rst_n is asserted and until the first rising edge after it is released.
  assign o         = (rst_n && en) ? c : '0;
  assign mem_rd    = o.mem_rd;
  assign mem_wr    = o.mem_wr;
  assign ar_ld_pc  = o.ar_ld_pc;
  assign ar_ld_dt  = o.ar_ld_dt;
  assign ar_inc    = o.ar_inc;
  assign pc_inc    = o.pc_inc;
  assign pc_ld_dt  = o.pc_ld_dt;
  assign dr_ld_mem = o.dr_ld_mem;
  assign dr_ld_ac  = o.dr_ld_ac;
  assign tr_ld_dr  = o.tr_ld_dr;
  assign ir_ld_dr  = o.ir_ld_dr;
  assign ac_ld     = o.ac_ld;
  assign r_ld      = o.r_ld;
  assign z_ld      = o.z_ld;
  assign alu_op    = o.alu_op;
  assign illegal   = o.illegal;
endmodule
